// File: rtl/checker_sched_pkg.sv
// checker_sched_pkg: shared state encoding and default sizing for the checker scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package checker_sched_pkg;

  localparam int LANES_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/checker_sched_if.sv
// checker_sched_if: run-control, compare-data and result signals of checker_sched.
// Latency: n/a (wires only).
// Backpressure: none; start is a pulse, results are held registers.
// Ports: master drives start/num_cmp/lane_mask/out_s/out_b and observes the results;
//        slave (the checker) is the mirror image.
interface checker_sched_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(LANES);

  logic                 start;
  logic [CNT_W-1:0]     num_cmp;
  logic [LANES-1:0]     lane_mask;
  logic [2*LANES-1:0]   out_s;
  logic [2*LANES-1:0]   out_b;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CNT_W-1:0]     err_count;
  logic                 err_valid;
  logic [LW-1:0]        first_err_lane;
  logic [CNT_W-1:0]     first_err_idx;

  modport master (
    output start, num_cmp, lane_mask, out_s, out_b,
    input  busy, done, pass, err_count, err_valid, first_err_lane, first_err_idx
  );

  modport slave (
    input  start, num_cmp, lane_mask, out_s, out_b,
    output busy, done, pass, err_count, err_valid, first_err_lane, first_err_idx
  );

endinterface

// File: rtl/checker_sched_lane_rr_sel.sv
// lane_rr_sel: next enabled lane strictly after cur_i, wrapping to the lowest enabled lane.
// Latency: combinational.
// Backpressure: none.
// Ports: cur_i current lane, mask_i enabled lanes, nxt_o selected next lane
//        (returns cur_i when no lane is enabled).
module lane_rr_sel #(
  parameter int LANES = 4,
  parameter int LW    = $clog2(LANES)
) (
  input  logic [LW-1:0]    cur_i,
  input  logic [LANES-1:0] mask_i,
  output logic [LW-1:0]    nxt_o
);

  logic found;

  // Scan offsets 1..LANES so that cur_i itself is the last candidate; this
  // makes a single-lane mask select the same lane every time.
  always_comb begin
    nxt_o = cur_i;
    found = 1'b0;
    for (int k = 1; k <= LANES; k++) begin
      if (!found && mask_i[(int'(cur_i) + k) % LANES]) begin
        nxt_o = LW'((int'(cur_i) + k) % LANES);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/checker_sched.sv
// checker_sched: time-multiplexes structural/behavioural lane-pair compares through one slot.
// Latency: start at edge N -> busy after N, compares at N+1..N+num_cmp, done after N+num_cmp+1.
// Backpressure: none; start outside IDLE or with num_cmp/lane_mask zero is dropped.
// Ports: clk, reset_L (sync active-low); bus (slave) carries start/num_cmp/lane_mask,
//        out_s/out_b lane pairs, and busy/done/pass/err_count/err_valid/first_err_*.
module checker_sched
  import checker_sched_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset_L,
  checker_sched_if.slave  bus
);

  localparam int              LW       = $clog2(LANES);
  localparam logic [LW-1:0]   LAST     = LW'(LANES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [LW-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_vld_q, err_vld_d;
  logic [LW-1:0]      fe_lane_q, fe_lane_d;
  logic [CNT_W-1:0]   fe_idx_q, fe_idx_d;
  logic               pass_q, pass_d;

  logic               start_ok;
  logic               cmp_en;
  logic               run_end;
  logic               mismatch;
  logic [1:0]         s_pair, b_pair;
  logic [LW-1:0]      rr_cur;
  logic [LANES-1:0]   rr_mask;
  logic [LW-1:0]      rr_nxt;

  assign start_ok = (state_q == ST_IDLE) && bus.start &&
                    (bus.num_cmp != '0) && (bus.lane_mask != '0);
  // RUN holds num_cmp compare cycles followed by one settle cycle (idx == num)
  // in which the final count is turned into the pass verdict.
  assign cmp_en   = (state_q == ST_RUN) && (idx_q != num_q);
  assign run_end  = (state_q == ST_RUN) && (idx_q == num_q);

  // In IDLE, asking for "next after the top lane" yields the lowest enabled
  // lane of the incoming mask, which is the first lane of the run.
  assign rr_cur  = (state_q == ST_IDLE) ? LAST : sel_q;
  assign rr_mask = (state_q == ST_IDLE) ? bus.lane_mask : mask_q;

  lane_rr_sel #(.LANES(LANES), .LW(LW)) u_rr (
    .cur_i  (rr_cur),
    .mask_i (rr_mask),
    .nxt_o  (rr_nxt)
  );

  always_comb begin
    s_pair = '0;
    b_pair = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sel_q == LW'(i)) begin
        s_pair = bus.out_s[2*i +: 2];
        b_pair = bus.out_b[2*i +: 2];
      end
    end
  end

  assign mismatch = (s_pair != b_pair);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN:  if (run_end)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy = (state_q == ST_RUN);
    bus.done = (state_q == ST_DONE);
  end

  // Datapath next state
  always_comb begin
    num_d     = num_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    err_cnt_d = err_cnt_q;
    err_vld_d = err_vld_q;
    fe_lane_d = fe_lane_q;
    fe_idx_d  = fe_idx_q;
    pass_d    = pass_q;

    if (start_ok) begin
      num_d     = bus.num_cmp;
      mask_d    = bus.lane_mask;
      idx_d     = '0;
      sel_d     = rr_nxt;
      err_cnt_d = '0;
      err_vld_d = 1'b0;
      fe_lane_d = '0;
      fe_idx_d  = '0;
      pass_d    = 1'b0;
    end

    if (cmp_en) begin
      idx_d = idx_q + 1'b1;
      sel_d = rr_nxt;
      if (mismatch) begin
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        if (!err_vld_q) begin
          err_vld_d = 1'b1;
          fe_lane_d = sel_q;
          fe_idx_d  = idx_q;
        end
      end
    end

    if (run_end) pass_d = (err_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      num_q     <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      sel_q     <= '0;
      err_cnt_q <= '0;
      err_vld_q <= 1'b0;
      fe_lane_q <= '0;
      fe_idx_q  <= '0;
      pass_q    <= 1'b0;
    end else begin
      num_q     <= num_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      err_cnt_q <= err_cnt_d;
      err_vld_q <= err_vld_d;
      fe_lane_q <= fe_lane_d;
      fe_idx_q  <= fe_idx_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.pass           = pass_q;
  assign bus.err_count      = err_cnt_q;
  assign bus.err_valid      = err_vld_q;
  assign bus.first_err_lane = fe_lane_q;
  assign bus.first_err_idx  = fe_idx_q;

endmodule

// File: tb/tb_checker_sched.sv
// tb_checker_sched: directed + random runs of checker_sched against a queue-based lane-order model.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: n/a.
module tb_checker_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L;
  logic       start;
  logic [7:0] num_cmp;
  logic [3:0] mask;
  logic [7:0] out_s, out_b;
  logic       which;   // 0: 8-bit counter DUT, 1: 4-bit counter DUT

  checker_sched_if #(.LANES(4), .CNT_W(8)) bus0 ();
  checker_sched_if #(.LANES(4), .CNT_W(4)) bus1 ();

  assign bus0.start     = start & ~which;
  assign bus0.num_cmp   = num_cmp;
  assign bus0.lane_mask = mask;
  assign bus0.out_s     = out_s;
  assign bus0.out_b     = out_b;
  assign bus1.start     = start & which;
  assign bus1.num_cmp   = num_cmp[3:0];
  assign bus1.lane_mask = mask;
  assign bus1.out_s     = out_s;
  assign bus1.out_b     = out_b;

  checker_sched #(.LANES(4), .CNT_W(8)) u0 (.clk(clk), .reset_L(reset_L), .bus(bus0));
  checker_sched #(.LANES(4), .CNT_W(4)) u1 (.clk(clk), .reset_L(reset_L), .bus(bus1));

  logic       o_busy, o_done, o_pass, o_vld;
  logic [7:0] o_err, o_fidx;
  logic [1:0] o_flane;
  assign o_busy  = which ? bus1.busy : bus0.busy;
  assign o_done  = which ? bus1.done : bus0.done;
  assign o_pass  = which ? bus1.pass : bus0.pass;
  assign o_vld   = which ? bus1.err_valid : bus0.err_valid;
  assign o_err   = which ? {4'b0, bus1.err_count} : bus0.err_count;
  assign o_fidx  = which ? {4'b0, bus1.first_err_idx} : bus0.first_err_idx;
  assign o_flane = which ? bus1.first_err_lane : bus0.first_err_lane;

  int errors = 0;
  int checks = 0;

  // reference model state
  int errs, fe_lane, fe_idx, exp_pass, done_seen;
  bit fe_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, o_busy}, 0);
    chk({tag, "_done"}, {31'b0, o_done}, 0);
    chk({tag, "_pass"}, {31'b0, o_pass}, 0);
    chk({tag, "_err"},  {24'b0, o_err},  0);
    chk({tag, "_vld"},  {31'b0, o_vld},  0);
    chk({tag, "_flane"},{30'b0, o_flane},0);
    chk({tag, "_fidx"}, {24'b0, o_fidx}, 0);
  endtask

  // Drive all lane pairs; only the expected lane's mismatch is controlled.
  task automatic drive(input int lane, input bit mis, input bit noisy);
    for (int j = 0; j < 4; j++) begin
      logic [1:0] s, b;
      s = 2'($urandom);
      if (j == lane)  b = mis ? (s ^ 2'($urandom_range(1, 3))) : s;
      else if (noisy) b = 2'($urandom);
      else            b = s;
      out_s[2*j +: 2] = s;
      out_b[2*j +: 2] = b;
    end
  endtask

  // mode: 0 all equal, 1 random mismatches, 2 single injected mismatch, 3 always mismatch
  task automatic run(input string tag, input int n, input logic [3:0] m, input int mode,
                     input bit restart, input int rst_at, input int inj_lane,
                     input int inj_idx, input int maxerr);
    int en[$];
    int lane;
    bit mis;
    for (int j = 0; j < 4; j++) if (m[j]) en.push_back(j);
    start = 1'b1; num_cmp = 8'(n); mask = m;
    @(negedge clk);
    start = restart;
    errs = 0; fe_vld = 0; fe_lane = 0; fe_idx = 0;
    chk({tag, "_start_busy"}, {31'b0, o_busy}, 1);
    chk({tag, "_start_err"},  {24'b0, o_err},  0);
    chk({tag, "_start_pass"}, {31'b0, o_pass}, 0);
    done_seen = 0;
    for (int k = 0; k < n; k++) begin
      lane = en[k % en.size()];
      case (mode)
        0: mis = 1'b0;
        1: mis = ($urandom_range(0, 2) == 0);
        2: mis = (lane == inj_lane) && (k == inj_idx);
        default: mis = 1'b1;
      endcase
      drive(lane, mis, mode != 0);
      if (k == rst_at) reset_L = 1'b0;
      @(negedge clk);
      if (k == rst_at) begin
        reset_L = 1'b1;
        start = 1'b0;
        exp_pass = 0;
        chk_all_zero({tag, "_rst"});
        return;
      end
      if (mis) begin
        if (errs < maxerr) errs++;
        if (!fe_vld) begin fe_vld = 1; fe_lane = lane; fe_idx = k; end
      end
      chk({tag, "_cnt"}, {24'b0, o_err}, errs);
      if (o_done) done_seen++;
      chk({tag, "_run_busy"}, {31'b0, o_busy}, 1);
    end
    drive(0, 1'b0, 1'b1);
    @(negedge clk);
    chk({tag, "_done"},      {31'b0, o_done}, 1);
    chk({tag, "_done_busy"}, {31'b0, o_busy}, 0);
    exp_pass = (errs == 0);
    chk({tag, "_pass"},  {31'b0, o_pass}, exp_pass);
    chk({tag, "_err"},   {24'b0, o_err},  errs);
    chk({tag, "_vld"},   {31'b0, o_vld},  fe_vld);
    if (fe_vld) begin
      chk({tag, "_flane"}, {30'b0, o_flane}, fe_lane);
      chk({tag, "_fidx"},  {24'b0, o_fidx},  fe_idx);
    end
    @(negedge clk);
    start = 1'b0;
    if (o_done) done_seen++;
    chk({tag, "_early_done"}, done_seen, 0);
    chk({tag, "_idle_busy"},  {31'b0, o_busy}, 0);
    chk({tag, "_hold_pass"},  {31'b0, o_pass}, exp_pass);
    chk({tag, "_hold_err"},   {24'b0, o_err},  errs);
  endtask

  initial begin
    reset_L = 1'b0; start = 1'b0; num_cmp = '0; mask = '0;
    out_s = '0; out_b = '0; which = 1'b0;
    exp_pass = 0;
    @(negedge clk); @(negedge clk);
    chk_all_zero("reset0");
    which = 1'b1;
    #1;
    chk_all_zero("reset1");
    which = 1'b0;
    reset_L = 1'b1;
    @(negedge clk);

    run("allmatch", 8, 4'b1111, 0, 0, -1, 0, 0, 255);
    run("inject",   5, 4'b1010, 2, 0, -1, 3, 3, 255);
    run("rand_a",  12, 4'b0110, 1, 0, -1, 0, 0, 255);
    run("single",   7, 4'b0100, 1, 0, -1, 0, 0, 255);
    for (int r = 0; r < 4; r++) begin
      logic [3:0] rm;
      rm = 4'($urandom_range(1, 15));
      run("rand_m", int'($urandom_range(1, 20)), rm, 1, 0, -1, 0, 0, 255);
    end
    run("errs_pre", 6, 4'b1111, 3, 0, -1, 0, 0, 255);

    // starts that must be dropped
    start = 1'b1; num_cmp = 8'd0; mask = 4'b1111;
    @(negedge clk);
    chk("ill_num_busy", {31'b0, o_busy}, 0);
    num_cmp = 8'd5; mask = 4'b0000;
    @(negedge clk);
    chk("ill_mask_busy", {31'b0, o_busy}, 0);
    chk("ill_mask_done", {31'b0, o_done}, 0);
    start = 1'b0;
    @(negedge clk);
    chk("ill_busy",  {31'b0, o_busy}, 0);
    chk("ill_done",  {31'b0, o_done}, 0);
    chk("ill_pass",  {31'b0, o_pass}, exp_pass);
    chk("ill_err",   {24'b0, o_err},  errs);

    run("restart", 6, 4'b1111, 1, 1, -1, 0, 0, 255);
    run("midrst",  8, 4'b1111, 1, 0, 3, 0, 0, 255);
    run("postrst", 8, 4'b1111, 1, 0, -1, 0, 0, 255);

    which = 1'b1;
    @(negedge clk);
    run("sat", 15, 4'b0001, 3, 0, -1, 0, 0, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
